// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of an external single-port synchronous RAM (1-cycle read).
// Define RAM_FIFO_ERR_EN to add sticky overflow/underflow flags (ovf, udf).
module ram_fifo_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              pop,
    output logic              pop_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              ram_w,
    output logic              ram_r,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do
`ifdef RAM_FIFO_ERR_EN
    ,
    output logic              ovf,
    output logic              udf
`endif
);

    localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_pop_vld_p1;

    logic w_full;
    logic w_empty;
    logic w_pop_rdy;
    logic w_push_rdy;
    logic w_push_acc;
    logic w_pop_acc;

    assign w_full     = (r_count == DEPTH);
    assign w_empty    = (r_count == '0);
    // An accepted pop owns the single RAM port, so it locks out push.
    assign w_pop_rdy  = !w_empty && !flush && !rst;
    assign w_push_rdy = !w_full && !flush && !rst && !(pop && w_pop_rdy);
    assign w_push_acc = push && w_push_rdy;
    assign w_pop_acc  = pop && w_pop_rdy;

    assign push_ready = w_push_rdy;
    assign pop_ready  = w_pop_rdy;
    assign full       = w_full;
    assign empty      = w_empty;
    assign count      = r_count;
    assign ram_w      = w_push_acc;
    assign ram_r      = w_pop_acc;

    always_comb begin
        ram_ad = '0;
        ram_di = '0;
        if (w_push_acc) begin
            ram_ad = r_wr_ptr;
            ram_di = push_data;
        end else if (w_pop_acc) begin
            ram_ad = r_rd_ptr;
        end
    end

    // Stage p0 -> p1: RAM read issued at p0, data returns with pop_valid at p1.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_pop_vld_p1 <= 1'b0;
        end else begin
            r_pop_vld_p1 <= w_pop_acc;
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
                r_count  <= r_count + CNT_ONE;
            end else if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_count  <= r_count - CNT_ONE;
            end
        end
    end

    assign pop_valid = r_pop_vld_p1;
    assign pop_data  = r_pop_vld_p1 ? ram_do : '0;

`ifdef RAM_FIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (push && w_full)
                ovf <= 1'b1;
            if (pop && w_empty)
                udf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: queue-based reference model plus a simple RAM model.
module tb_ram_fifo_ctrl;
    localparam int AW    = 8;
    localparam int DW    = 4;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          push = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          push_ready;
    logic          pop = 1'b0;
    logic          pop_ready;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ram_w;
    logic          ram_r;
    logic [AW-1:0] ram_ad;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do;
`ifdef RAM_FIFO_ERR_EN
    logic          ovf;
    logic          udf;
    bit            e_ovf = 1'b0;
    bit            e_udf = 1'b0;
`endif

    logic [DW-1:0] mem [DEPTH];

    logic [DW-1:0] dq[$];
    int            wptr_m = 0;
    int            rptr_m = 0;
    bit            exp_vld = 1'b0;
    logic [DW-1:0] exp_pdata = '0;
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push(push), .push_data(push_data), .push_ready(push_ready),
        .pop(pop), .pop_ready(pop_ready), .pop_data(pop_data), .pop_valid(pop_valid),
        .full(full), .empty(empty), .count(count),
        .ram_w(ram_w), .ram_r(ram_r), .ram_ad(ram_ad), .ram_di(ram_di), .ram_do(ram_do)
`ifdef RAM_FIFO_ERR_EN
        , .ovf(ovf), .udf(udf)
`endif
    );

    // Single-port RAM with registered read data
    always @(posedge clk) begin
        if (ram_w)
            mem[ram_ad] <= ram_di;
        if (ram_r)
            ram_do <= mem[ram_ad];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check everything at negedge, advance model.
    task automatic cyc(input logic i_push, input logic [DW-1:0] d, input logic i_pop,
                       input logic i_flush, input logic i_rst);
        bit prdy, wrdy, pacc, wacc;
        int n;
        push = i_push; push_data = d; pop = i_pop; flush = i_flush; rst = i_rst;
        @(negedge clk);
        n    = dq.size();
        prdy = !i_rst && !i_flush && (n != 0);
        wrdy = !i_rst && !i_flush && (n != DEPTH) && !(i_pop && prdy);
        pacc = i_pop && prdy;
        wacc = i_push && wrdy;
        chk("push_ready", 32'(push_ready), 32'(wrdy));
        chk("pop_ready",  32'(pop_ready),  32'(prdy));
        chk("ram_w",      32'(ram_w),      32'(wacc));
        chk("ram_r",      32'(ram_r),      32'(pacc));
        chk("ram_ad",     32'(ram_ad),     wacc ? 32'(wptr_m) : (pacc ? 32'(rptr_m) : 32'd0));
        chk("ram_di",     32'(ram_di),     wacc ? 32'(d) : 32'd0);
        chk("count",      32'(count),      32'(n));
        chk("empty",      32'(empty),      32'(n == 0));
        chk("full",       32'(full),       32'(n == DEPTH));
        chk("pop_valid",  32'(pop_valid),  32'(exp_vld));
        if (exp_vld)
            chk("pop_data", 32'(pop_data), 32'(exp_pdata));
`ifdef RAM_FIFO_ERR_EN
        chk("ovf", 32'(ovf), 32'(e_ovf));
        chk("udf", 32'(udf), 32'(e_udf));
`endif
        if (i_rst || i_flush) begin
            dq.delete();
            wptr_m  = 0;
            rptr_m  = 0;
            exp_vld = 1'b0;
`ifdef RAM_FIFO_ERR_EN
            e_ovf = 1'b0;
            e_udf = 1'b0;
`endif
        end else begin
`ifdef RAM_FIFO_ERR_EN
            if (i_push && n == DEPTH) e_ovf = 1'b1;
            if (i_pop && n == 0)      e_udf = 1'b1;
`endif
            exp_vld = pacc;
            if (pacc) begin
                exp_pdata = dq.pop_front();
                rptr_m    = (rptr_m + 1) % DEPTH;
            end
            if (wacc) begin
                dq.push_back(d);
                wptr_m = (wptr_m + 1) % DEPTH;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Reset held with requests present: handshakes must stay low
        cyc(1'b1, 4'h5, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_pop_data", 32'(pop_data), 32'd0);
        chk("rst_empty",    32'(empty),    32'd1);

        // Three pushes then three pops
        cyc(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
        chk("cnt3", 32'(count), 32'd3);
        chk("not_empty", 32'(empty), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("data6", 32'(pop_data), 32'd6);
        for (int i = 0; i < 2; i++) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("cnt0", 32'(count), 32'd0);

        // Fill to full, overflow attempt, pop-over-push priority, drain
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        chk("cnt256", 32'(count), 32'd256);
        chk("full1",  32'(full),  32'd1);
        cyc(1'b1, 4'hA, 1'b1, 1'b0, 1'b0);
        chk("cnt255", 32'(count), 32'd255);
        cyc(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Simultaneous push/pop at count 5 and at count 0
        for (int i = 0; i < 5; i++) cyc(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
        chk("cnt4", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
        chk("cnt1", 32'(count), 32'd1);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Alternating pairs to wrap the pointers
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
            chk("cnt_le1", 32'(count <= 1), 32'd1);
        end
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Flush, then reset, one cycle after a pop accept
        for (int i = 0; i < 3; i++) cyc(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 4'h3, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("flush_vld",   32'(pop_valid), 32'd0);
        chk("flush_empty", 32'(empty),     32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 4'h3, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_vld",   32'(pop_valid), 32'd0);
        chk("rst_count", 32'(count),     32'd0);

        // Random traffic with occasional flush
        for (int i = 0; i < 600; i++)
            cyc(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 63) == 0), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: RAM address width; FIFO depth is 2^ADDR_W (256).
REQ-002 SHALL have parameter DATA_W, default 4: data word width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port flush, input, 1: synchronous FIFO clear.
REQ-006 SHALL have port push, input, 1: write request.
REQ-007 SHALL have port push_data, input, DATA_W: write word.
REQ-008 SHALL have port push_ready, output, 1: push accepted this cycle when push && push_ready.
REQ-009 SHALL have port pop, input, 1: read request.
REQ-010 SHALL have port pop_ready, output, 1: pop accepted this cycle when pop && pop_ready.
REQ-011 SHALL have port pop_data, output, DATA_W: read word, valid only while pop_valid is high.
REQ-012 SHALL have port pop_valid, output, 1: pop_data valid this cycle.
REQ-013 SHALL have ports full and empty, output, 1 each: occupancy flags.
REQ-014 SHALL have port count, output, ADDR_W+1: occupancy, range 0..256.
REQ-015 SHALL have ports ram_w, ram_r, output, 1 each: write and read strobes to the single-port RAM.
REQ-016 SHALL have ports ram_ad, output, ADDR_W; ram_di, output, DATA_W; ram_do, input, DATA_W: RAM address, write data and read data.

Function
REQ-017 SHALL treat the RAM as single-port: ram_w and ram_r never high in the same cycle.
REQ-018 SHALL drive pop_ready = !empty && !flush && !rst.
REQ-019 SHALL drive push_ready = !full && !flush && !rst && !(pop && pop_ready): an accepted pop has priority over push.
REQ-020 SHALL drive ram_w = push && push_ready, with ram_ad = wr_ptr and ram_di = push_data, combinationally in the accept cycle.
REQ-021 SHALL drive ram_r = pop && pop_ready, with ram_ad = rd_ptr, combinationally in the accept cycle.
REQ-022 SHALL drive ram_ad = 0 and ram_di = 0 when neither strobe is high.
REQ-023 SHALL assert pop_valid exactly one cycle after each accepted pop and drive pop_data = ram_do in that cycle; pop latency is 1 cycle, with back-to-back pops giving one word per cycle.
REQ-024 SHALL increment wr_ptr on each accepted push and rd_ptr on each accepted pop, modulo 2^ADDR_W (255 wraps to 0).
REQ-025 SHALL update count +1 on accepted push and -1 on accepted pop; both in one cycle is impossible per REQ-017 and REQ-019.
REQ-026 SHALL derive empty = (count == 0) and full = (count == 2^ADDR_W), from registered count.
REQ-027 SHALL, for push and pop with empty FIFO, accept push only; pop_ready stays low.
REQ-028 SHALL, for push and pop with full FIFO, accept pop only; push is accepted in a later cycle.
REQ-029 SHALL leave all state unchanged, with no RAM strobe, when push is requested while full or pop is requested while empty.
REQ-030 SHALL, on flush, zero wr_ptr, rd_ptr and count at the next edge, block both handshakes that cycle, and force pop_valid low in the following cycle; RAM contents are not cleared.

Reset
REQ-031 SHALL, while rst is high at a clock edge, set wr_ptr = 0, rd_ptr = 0, count = 0 and pop_valid = 0.
REQ-032 SHALL hold push_ready = 0, pop_ready = 0, ram_w = 0 and ram_r = 0 while rst is high.
REQ-033 SHALL, after reset, present empty = 1, full = 0, count = 0 and pop_data = 0.
REQ-034 SHALL, when rst is asserted mid-operation, discard any in-flight pop with no pop_valid pulse in the next cycle; rst has priority over flush.

Configuration
REQ-035 SHALL, with RAM_FIFO_ERR_EN defined, add outputs ovf and udf (1 bit each).
REQ-036 SHALL set ovf sticky-high on push while full and udf sticky-high on pop while empty; both cleared only by rst or flush.
REQ-037 SHALL, without RAM_FIFO_ERR_EN, omit ovf, udf and their logic entirely; all other behaviour is identical.

Verification
REQ-038 SHALL cover: reset, then push 0x1, 0x2, 0x6 on consecutive cycles -> ram_w high with ram_ad 0, 1, 2 and ram_di 1, 2, 6; count = 3; empty = 0.
REQ-039 SHALL cover: then pop on 3 consecutive cycles -> ram_r with ram_ad 0, 1, 2; pop_valid on the following 3 cycles with pop_data 1, 2, 6; count = 0; empty = 1.
REQ-040 SHALL cover: push 256 words, then one more push -> full = 1, push_ready = 0, RAM untouched, count = 256; with RAM_FIFO_ERR_EN, ovf = 1.
REQ-041 SHALL cover: push and pop together with count = 5 -> ram_r only, count = 4; with count = 0 -> ram_w only, count = 1.
REQ-042 SHALL cover: 300 alternating push/pop pairs -> pointers wrap past 255, data order preserved, count never above 1.
REQ-043 SHALL cover: flush, or rst, the cycle after a pop accept with count = 3 -> no pop_valid next cycle; count = 0; empty = 1.
